// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: top-level layer scheduler for the CNN accelerator.
// Walks LOAD -> CONV1 -> POOL1 -> CONV2 -> POOL2 -> FC, driving the layer
// opcode into CNN_ctrl. A layer advances only on a matching return code
// received after the guard window. A per-layer watchdog moves the sequencer
// to ERR. Busy/done/error status and cycle counters feed the register file.
// Optional feature macro: CNN_SEQ_PERF_EN (adds per-layer cycle counters).
module cnn_layer_sequencer #(
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_img_loaded,
    input  logic             i_abort,
    input  logic [7:0]       i_return_ctrl,
    output logic [7:0]       o_ctrl,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [2:0]       o_layer_idx,
    output logic [CNT_W-1:0] o_total_cycles,
    input  logic [2:0]       i_perf_sel,
    output logic [CNT_W-1:0] o_perf_cnt
);

    // Encoding keeps the reported layer index in the low three bits.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_CONV1 = 4'd2,
        S_POOL1 = 4'd3,
        S_CONV2 = 4'd4,
        S_POOL2 = 4'd5,
        S_FC    = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    localparam int                 GUARD_W    = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
    localparam logic [24:0]        WD_LAST    = 25'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    // Opcode sent to CNN_ctrl for a layer state (LOAD maps to 0).
    function automatic logic [7:0] layer_code(input state_t s);
        return {5'd0, s[2:0] - 3'd1};
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [GUARD_W-1:0] r_guard;
    logic [24:0]        r_wd;
    logic [7:0]         r_ctrl;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [2:0]         r_layer_idx;
    logic [CNT_W-1:0]   r_total;
    logic               w_busy_now;
    logic               w_guard_done;
    logic               w_step_ok;
    logic               w_start_req;
    logic               w_entry;
    logic               w_restart;

    assign w_busy_now   = (r_state >= S_LOAD) && (r_state <= S_FC);
    assign w_guard_done = (r_guard == '0);
    assign w_step_ok    = (r_state == S_LOAD) ? i_img_loaded
                                              : (i_return_ctrl == layer_code(r_state));
    assign w_start_req  = i_start && !i_abort;
    assign w_entry      = (w_next != r_state);
    assign w_restart    = (w_next == S_LOAD) && (r_state != S_LOAD);

    // Next-state selection: abort > watchdog expiry > layer advance > start.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_req) w_next = S_LOAD;
                else             w_next = S_IDLE;
            end
            S_LOAD, S_CONV1, S_POOL1, S_CONV2, S_POOL2, S_FC: begin
                if (i_abort)                        w_next = S_IDLE;
                else if (r_wd == WD_LAST)           w_next = S_ERR;
                else if (w_guard_done && w_step_ok) w_next = state_t'(r_state + 4'd1);
                else                                w_next = r_state;
            end
            S_DONE, S_ERR: begin
                if (i_abort)      w_next = S_IDLE;
                else if (i_start) w_next = S_LOAD;
                else              w_next = r_state;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Guard window: reloads on every state entry, counts down to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)             r_guard <= '0;
        else if (w_entry)         r_guard <= GUARD_LOAD;
        else if (!w_guard_done)   r_guard <= r_guard - GUARD_W'(1);
        else                      r_guard <= r_guard;
    end

    // Watchdog: cleared on state entry, counts cycles spent in a busy state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                    r_wd <= '0;
        else if (w_entry || !w_busy_now) r_wd <= '0;
        else                             r_wd <= r_wd + 25'd1;
    end

    // Status outputs decoded from the state being entered, so they change with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl      <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_layer_idx <= 3'd0;
        end else begin
            r_busy  <= (w_next >= S_LOAD) && (w_next <= S_FC);
            r_done  <= (w_next == S_DONE);
            r_error <= (w_next == S_ERR);
            if ((w_next >= S_CONV1) && (w_next <= S_FC)) r_ctrl <= layer_code(w_next);
            else                                         r_ctrl <= 8'd0;
            if (w_next == S_ERR) begin
                // ERR reports the layer whose watchdog fired.
                if (r_state != S_ERR) r_layer_idx <= r_state[2:0];
                else                  r_layer_idx <= r_layer_idx;
            end else begin
                r_layer_idx <= w_next[2:0];
            end
        end
    end

    // Total busy-cycle counter: cleared on (re)start, saturating, frozen when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                             r_total <= '0;
        else if (w_restart)                       r_total <= '0;
        else if (w_busy_now && r_total != CNT_MAX) r_total <= r_total + CNT_W'(1);
        else                                      r_total <= r_total;
    end

    assign o_ctrl         = r_ctrl;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_layer_idx    = r_layer_idx;
    assign o_total_cycles = r_total;

`ifdef CNN_SEQ_PERF_EN
    logic [CNT_W-1:0] r_perf [0:5];
    logic [CNT_W-1:0] r_perf_cnt;
    logic [2:0]       w_slot;

    assign w_slot = r_state[2:0] - 3'd1;

    // Per-layer occupancy counters, one per busy state, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 6; i++) r_perf[i] <= '0;
        end else if (w_restart) begin
            for (int i = 0; i < 6; i++) r_perf[i] <= '0;
        end else if (w_busy_now && (r_perf[w_slot] != CNT_MAX)) begin
            r_perf[w_slot] <= r_perf[w_slot] + CNT_W'(1);
        end else begin
            r_perf[w_slot] <= r_perf[w_slot];
        end
    end

    // Registered read mux; selects outside 1..6 read as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                   r_perf_cnt <= '0;
        else if ((i_perf_sel >= 3'd1) && (i_perf_sel <= 3'd6)) r_perf_cnt <= r_perf[i_perf_sel - 3'd1];
        else                                            r_perf_cnt <= '0;
    end

    assign o_perf_cnt = r_perf_cnt;
`else
    logic w_unused_perf_sel;
    assign w_unused_perf_sel = ^i_perf_sel;
    assign o_perf_cnt        = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model
// that tracks the layer index and the number of cycles spent in each layer.
module tb_cnn_layer_sequencer;
    localparam int GUARD = 2;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        img_loaded = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  return_ctrl = 8'd0;
    logic [2:0]  perf_sel = 3'd0;
    logic [7:0]  o_ctrl;
    logic        o_busy, o_done, o_error;
    logic [2:0]  o_layer_idx;
    logic [31:0] o_total_cycles, o_perf_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1..6 = LOAD..FC, 7 done, 8 error
    int          m_st, m_n, m_fail;
    logic [31:0] m_total, m_perf_out;
    logic [31:0] m_perf [1:6];

    // CNN_ctrl stand-in
    int drv_prev = -1, drv_age = 0, drv_delay = 10;
    bit rand_mode = 1'b0, hold_pool1 = 1'b0, glitch = 1'b0;

    cnn_layer_sequencer #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_img_loaded(img_loaded),
        .i_abort(abort), .i_return_ctrl(return_ctrl), .o_ctrl(o_ctrl), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error), .o_layer_idx(o_layer_idx),
        .o_total_cycles(o_total_cycles), .i_perf_sel(perf_sel), .o_perf_cnt(o_perf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_n = 0; m_fail = 0; m_total = 32'd0; m_perf_out = 32'd0;
        for (int i = 1; i <= 6; i++) m_perf[i] = 32'd0;
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_edge();
        int nxt;
        m_perf_out = (perf_sel >= 3'd1 && perf_sel <= 3'd6) ? m_perf[perf_sel] : 32'd0;
        nxt = m_st;
        if (m_st >= 1 && m_st <= 6) begin
            m_n++;
            if (m_total != 32'hFFFF_FFFF) m_total++;
            if (m_perf[m_st] != 32'hFFFF_FFFF) m_perf[m_st]++;
            if (abort) nxt = 0;
            else if (m_n == TMO) begin nxt = 8; m_fail = m_st; end
            else if (m_n > GUARD && ((m_st == 1) ? (img_loaded == 1'b1) : (int'(return_ctrl) == m_st - 1)))
                nxt = m_st + 1;
        end else if (m_st != 0 && abort) begin
            nxt = 0;
        end else if (start && !abort) begin
            nxt = 1; m_total = 32'd0;
            for (int i = 1; i <= 6; i++) m_perf[i] = 32'd0;
        end
        if (nxt != m_st) m_n = 0;
        m_st = nxt;
    endtask

    task automatic compare_all();
        check_eq("ctrl", o_ctrl, (m_st >= 2 && m_st <= 6) ? m_st - 1 : 0);
        check_eq("busy", o_busy, (m_st >= 1 && m_st <= 6) ? 1 : 0);
        check_eq("done", o_done, (m_st == 7) ? 1 : 0);
        check_eq("error", o_error, (m_st == 8) ? 1 : 0);
        check_eq("layer_idx", o_layer_idx, (m_st == 8) ? m_fail : m_st);
        check_eq("total_cycles", o_total_cycles, m_total);
`ifdef CNN_SEQ_PERF_EN
        check_eq("perf_cnt", o_perf_cnt, m_perf_out);
`else
        check_eq("perf_cnt", o_perf_cnt, 0);
`endif
    endtask

    // Return code from the CNN_ctrl stand-in: code k some cycles after ctrl=k, junk before.
    task automatic drive_return();
        int k, junk;
        k = int'(o_ctrl);
        if (k != drv_prev) begin
            drv_prev = k; drv_age = 0;
            drv_delay = rand_mode ? $urandom_range(0, 15) : 10;
        end else begin
            drv_age++;
        end
        junk = $urandom_range(0, 255);
        if (k == 0)                                         return_ctrl = 8'(junk);
        else if (hold_pool1 && k == 2)                      return_ctrl = 8'd1;
        else if (drv_age >= drv_delay + 1 || (glitch && drv_age <= 1)) return_ctrl = 8'(k);
        else                                                return_ctrl = (junk == k) ? 8'(k - 1) : 8'(junk);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        drive_return();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    // what: 0..5 = busy with that ctrl code, 7 = done, 8 = error
    task automatic wait_for(input string tag, input int what, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            if (what == 7)      hit = o_done;
            else if (what == 8) hit = o_error;
            else                hit = o_busy && (int'(o_ctrl) == what);
        end
        check_eq({tag, "_reached"}, hit, 1);
    endtask

    initial begin
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // 1: nominal run, fixed 10-cycle CNN_ctrl latency
        img_loaded = 1'b1;
        pulse_start();
        wait_for("t1_done", 7, 200);
        check_eq("t1_total", o_total_cycles, 63);
        perf_sel = 3'd2; step(); step();
`ifdef CNN_SEQ_PERF_EN
        check_eq("t6_perf_conv1", o_perf_cnt, 12);
`else
        check_eq("t6_perf_off", o_perf_cnt, 0);
`endif
        perf_sel = 3'd0; step(); step();
        check_eq("t6_perf_sel0", o_perf_cnt, 0);

        // 2: stale code held through POOL1 -> watchdog
        hold_pool1 = 1'b1;
        pulse_start();
        wait_for("t2_err", 8, 200);
        hold_pool1 = 1'b0;
        check_eq("t2_ctrl", o_ctrl, 0);
        check_eq("t2_layer", o_layer_idx, 3);
        check_eq("t2_busy", o_busy, 0);
        check_eq("t2_total", o_total_cycles, 31);

        // 3: matching code only inside the guard window is ignored
        glitch = 1'b1;
        pulse_start();
        wait_for("t3_done", 7, 200);
        glitch = 1'b0;
        check_eq("t3_total", o_total_cycles, 63);

        // 4: abort mid-CONV2; start+abort together in DONE
        pulse_start();
        wait_for("t4_conv2", 3, 200);
        abort = 1'b1; step(); abort = 1'b0;
        check_eq("t4_abort_ctrl", o_ctrl, 0);
        check_eq("t4_abort_busy", o_busy, 0);
        check_eq("t4_abort_layer", o_layer_idx, 0);
        abort = 1'b1; step(); abort = 1'b0;
        check_eq("t4_idle_abort", o_layer_idx, 0);
        pulse_start();
        wait_for("t4_done", 7, 200);
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check_eq("t4_both_layer", o_layer_idx, 0);
        check_eq("t4_both_done", o_done, 0);

        // 5: start ignored while busy; restart from DONE clears status
        pulse_start();
        wait_for("t5_conv1", 1, 200);
        pulse_start();
        check_eq("t5_ignored", o_ctrl, 1);
        wait_for("t5_done", 7, 200);
        pulse_start();
        check_eq("t5_done_clr", o_done, 0);
        check_eq("t5_busy", o_busy, 1);
        check_eq("t5_total_clr", o_total_cycles, 0);
        check_eq("t5_layer", o_layer_idx, 1);

        // 6: asynchronous reset in the middle of FC
        wait_for("t6_fc", 5, 200);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        rand_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            start      = ($urandom_range(0, 19) == 0);
            abort      = ($urandom_range(0, 149) == 0);
            img_loaded = ($urandom_range(0, 3) != 0);
            perf_sel   = 3'($urandom_range(0, 7));
            glitch     = ($urandom_range(0, 1) == 1);
            step();
        end
        start = 1'b0; abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
